// File: rtl/ariane_pkg.sv
// ============================================================================
//  Module      : ariane_pkg
//  Description : Runtime-monitor lane types shared by the allocator and
//                the lane tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ariane_pkg;

   localparam int unsigned RM_LANE_W = 2;

   typedef struct packed {
      logic                 monitor_ins;
      logic [RM_LANE_W-1:0] lane;
   } runtime_monitor_ctrl;

   typedef struct packed {
      logic                 reset_lane;
      logic [RM_LANE_W-1:0] lane;
   } lane_ctrl;

   typedef enum logic [1:0] {
      RM_IDLE      = 2'd0,
      RM_ISSUED    = 2'd1,
      RM_COMMITTED = 2'd2,
      RM_RELEASE   = 2'd3
   } rm_lane_state_e;

endpackage

`default_nettype wire

// File: rtl/rm_lane_fsm.sv
// ============================================================================
//  Module      : rm_lane_fsm
//  Description : Lifetime state machine and commit watchdog for one lane.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rm_lane_fsm
   import ariane_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           i_alloc,
   input  logic           i_commit,
   input  logic           i_flush,
   input  logic           i_done,
   input  logic           i_grant,
   output rm_lane_state_e o_state,
   output logic           o_release_req,
   output logic           o_timeout,
   output logic           o_err
);

   localparam int unsigned        C_CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [C_CNT_W-1:0] C_EXPIRE  = C_CNT_W'(TIMEOUT - 1);
   localparam logic               C_WDOG_EN = (TIMEOUT != 0);

   rm_lane_state_e     r_state;
   rm_lane_state_e     w_state_nxt;
   logic [C_CNT_W-1:0] r_cnt;
   logic [C_CNT_W-1:0] w_cnt_nxt;
   logic               w_expire;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= RM_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_expire    = 1'b0;
      o_timeout   = 1'b0;
      case (r_state)
         RM_IDLE: begin
            if (i_alloc) w_state_nxt = RM_ISSUED;
         end
         RM_ISSUED: begin
            // a commit racing a flush belongs to an older instruction, so it wins
            if (i_commit) begin
               w_state_nxt = RM_COMMITTED;
               w_cnt_nxt   = '0;
            end else if (i_flush) begin
               w_state_nxt = RM_RELEASE;
            end
         end
         RM_COMMITTED: begin
            w_expire  = C_WDOG_EN && (r_cnt == C_EXPIRE);
            o_timeout = w_expire && !i_done;
            if (i_done || w_expire) w_state_nxt = RM_RELEASE;
            else                    w_cnt_nxt   = r_cnt + 1'b1;
         end
         RM_RELEASE: begin
            if (i_grant) w_state_nxt = i_alloc ? RM_ISSUED : RM_IDLE;
         end
         default: w_state_nxt = RM_IDLE;
      endcase
      o_err = (i_alloc  && !((r_state == RM_IDLE) || (r_state == RM_RELEASE && i_grant)))
           || (i_done   && (r_state != RM_COMMITTED))
           || (i_commit && (r_state != RM_ISSUED));
   end

   assign o_state       = r_state;
   assign o_release_req = (r_state == RM_RELEASE);

endmodule

`default_nettype wire

// File: rtl/rm_lane_tracker.sv
// ============================================================================
//  Module      : rm_lane_tracker
//  Description : Tracks monitor lanes from allocation to release and drives
//                the allocator's lane-release bus from registered state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rm_lane_tracker
   import ariane_pkg::*;
#(
   parameter int unsigned NUM_LANES       = 4,
   parameter int unsigned NUM_EVENTS      = 10,
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned TIMEOUT         = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  runtime_monitor_ctrl        monitor_i,
   input  logic                       flush_i,
   input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
   input  runtime_monitor_ctrl        commit_monitor_i [NR_COMMIT_PORTS],
   input  logic [NUM_LANES-1:0]       check_done_i,
   output lane_ctrl                   reset_monitor_o  [NUM_EVENTS],
   output logic [NUM_LANES-1:0]       busy_o,
   output logic                       timeout_o,
   output logic                       error_o
);

   logic [NUM_LANES-1:0] w_alloc;
   logic [NUM_LANES-1:0] w_commit;
   logic [NUM_LANES-1:0] w_grant;
   logic [NUM_LANES-1:0] w_release_req;
   logic [NUM_LANES-1:0] w_timeout;
   logic [NUM_LANES-1:0] w_err;
   logic                 w_found;
   rm_lane_state_e       w_state [NUM_LANES];
   logic                 r_error;

   always_comb begin
      w_alloc  = '0;
      w_commit = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         w_alloc[l] = monitor_i.monitor_ins && !flush_i && (monitor_i.lane == RM_LANE_W'(l));
         for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (commit_ack_i[p] && commit_monitor_i[p].monitor_ins &&
                (commit_monitor_i[p].lane == RM_LANE_W'(l)))
               w_commit[l] = 1'b1;
         end
      end
   end

   // Each slot takes the lowest-index releasing lane not already taken.
   always_comb begin
      w_grant = '0;
      w_found = 1'b0;
      for (int s = 0; s < NUM_EVENTS; s++) begin
         reset_monitor_o[s] = '0;
         w_found            = 1'b0;
         for (int l = 0; l < NUM_LANES; l++) begin
            if (!w_found && w_release_req[l] && !w_grant[l]) begin
               w_found                       = 1'b1;
               w_grant[l]                    = 1'b1;
               reset_monitor_o[s].reset_lane = 1'b1;
               reset_monitor_o[s].lane       = RM_LANE_W'(l);
            end
         end
      end
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      rm_lane_fsm #(
         .TIMEOUT (TIMEOUT)
      ) u_fsm (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .i_alloc       (w_alloc[l]),
         .i_commit      (w_commit[l]),
         .i_flush       (flush_i),
         .i_done        (check_done_i[l]),
         .i_grant       (w_grant[l]),
         .o_state       (w_state[l]),
         .o_release_req (w_release_req[l]),
         .o_timeout     (w_timeout[l]),
         .o_err         (w_err[l])
      );
      assign busy_o[l] = (w_state[l] != RM_IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)       r_error <= 1'b0;
      else if (|w_err) r_error <= 1'b1;
   end

   assign error_o   = r_error;
   assign timeout_o = |w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rm_lane_tracker.sv
// ============================================================================
//  Module      : tb_rm_lane_tracker
//  Description : Scenario bench for rm_lane_tracker with a release scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rm_lane_tracker;
   import ariane_pkg::*;

   localparam int NL = 4;
   localparam int NE = 2;
   localparam int NP = 2;
   localparam int TO = 4;

   logic                clk_i = 1'b0;
   logic                rst_i = 1'b1;
   runtime_monitor_ctrl monitor_i;
   logic                flush_i;
   logic [NP-1:0]       commit_ack_i;
   runtime_monitor_ctrl commit_monitor_i [NP];
   logic [NL-1:0]       check_done_i;
   lane_ctrl            reset_monitor_o  [NE];
   logic [NL-1:0]       busy_o;
   logic                timeout_o;
   logic                error_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int lane;
      int slot;
      int cyc;
   } exp_t;
   exp_t sb[$];

   rm_lane_tracker #(
      .NUM_LANES       (NL),
      .NUM_EVENTS      (NE),
      .NR_COMMIT_PORTS (NP),
      .TIMEOUT         (TO)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .monitor_i        (monitor_i),
      .flush_i          (flush_i),
      .commit_ack_i     (commit_ack_i),
      .commit_monitor_i (commit_monitor_i),
      .check_done_i     (check_done_i),
      .reset_monitor_o  (reset_monitor_o),
      .busy_o           (busy_o),
      .timeout_o        (timeout_o),
      .error_o          (error_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Release-bus scoreboard: every asserted slot must match the next expectation.
   always @(negedge clk_i) begin
      exp_t e;
      for (int s = 0; s < NE; s++) begin
         checks++;
         if (reset_monitor_o[s].reset_lane === 1'b1) begin
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL release_unexpected: slot %0d lane %0d at cycle %0d, expected no release",
                        s, reset_monitor_o[s].lane, cyc);
            end else begin
               e = sb.pop_front();
               if (int'(reset_monitor_o[s].lane) != e.lane || s != e.slot || cyc != e.cyc) begin
                  failures++;
                  $display("FAIL release_match: got lane %0d slot %0d cycle %0d, expected lane %0d slot %0d cycle %0d",
                           reset_monitor_o[s].lane, s, cyc, e.lane, e.slot, e.cyc);
               end
            end
         end else if (reset_monitor_o[s] !== '0) begin
            failures++;
            $display("FAIL unused_slot: slot %0d = %0h, expected 0", s, reset_monitor_o[s]);
         end
      end
   end

   task automatic idle();
      monitor_i    = '0;
      flush_i      = 1'b0;
      commit_ack_i = '0;
      check_done_i = '0;
      for (int p = 0; p < NP; p++) commit_monitor_i[p] = '0;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      idle();
   endtask

   task automatic alloc(input int l);
      monitor_i.monitor_ins = 1'b1;
      monitor_i.lane        = 2'(l);
   endtask

   task automatic commit(input int p, input int l);
      commit_ack_i[p]                 = 1'b1;
      commit_monitor_i[p].monitor_ins = 1'b1;
      commit_monitor_i[p].lane        = 2'(l);
   endtask

   task automatic expect_rel(input int lane, input int slot, input int c);
      exp_t e;
      e.lane = lane;
      e.slot = slot;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s_drain: %0d releases outstanding, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      idle();
      repeat (2) @(posedge clk_i);
      #1;
      checks++;
      if (busy_o !== 4'b0000) begin failures++; $display("FAIL reset_busy: got %b expected 0000", busy_o); end
      checks++;
      if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
      checks++;
      if (error_o !== 1'b0) begin failures++; $display("FAIL reset_error: got %b expected 0", error_o); end
      for (int s = 0; s < NE; s++) begin
         checks++;
         if (reset_monitor_o[s] !== '0) begin
            failures++;
            $display("FAIL reset_bus: slot %0d got %0h expected 0", s, reset_monitor_o[s]);
         end
      end
      rst_i = 1'b0;
   endtask

   task automatic test_lifetime();
      int  t0 = 0;
      logic exp_busy;
      for (int r = 0; r <= 9; r++) begin
         tick();
         if (r == 0) t0 = cyc;
         case (r)
            0: alloc(2);
            3: commit(1, 2);
            6: begin check_done_i[2] = 1'b1; expect_rel(2, 0, t0 + 7); end
            default: ;
         endcase
         #1;
         exp_busy = (r >= 1 && r <= 7);
         checks++;
         if (busy_o[2] !== exp_busy) begin
            failures++;
            $display("FAIL lifetime_busy r%0d: got %b expected %b", r, busy_o[2], exp_busy);
         end
      end
      checks++;
      if (error_o !== 1'b0) begin failures++; $display("FAIL lifetime_error: got %b expected 0", error_o); end
      drain("lifetime");
   endtask

   task automatic test_flush();
      int t0 = 0;
      for (int r = 0; r <= 9; r++) begin
         tick();
         if (r == 0) t0 = cyc;
         case (r)
            0: alloc(0);
            1: alloc(1);
            2: alloc(3);
            3: commit(0, 3);
            5: begin flush_i = 1'b1; expect_rel(0, 0, t0 + 6); expect_rel(1, 1, t0 + 6); end
            6: begin check_done_i[3] = 1'b1; expect_rel(3, 0, t0 + 7); end
            default: ;
         endcase
         #1;
         checks++;
         if (timeout_o !== 1'b0) begin failures++; $display("FAIL flush_timeout r%0d: got %b expected 0", r, timeout_o); end
         if (r == 6) begin
            checks++;
            if (busy_o !== 4'b1011) begin failures++; $display("FAIL flush_busy6: got %b expected 1011", busy_o); end
         end
         if (r == 7) begin
            checks++;
            if (busy_o !== 4'b1000) begin failures++; $display("FAIL flush_busy7: got %b expected 1000", busy_o); end
         end
         if (r == 8) begin
            checks++;
            if (busy_o !== 4'b0000) begin failures++; $display("FAIL flush_busy8: got %b expected 0000", busy_o); end
         end
      end
      drain("flush");
   endtask

   task automatic test_collision();
      int t0 = 0;
      for (int r = 0; r <= 7; r++) begin
         tick();
         if (r == 0) t0 = cyc;
         case (r)
            0: alloc(1);
            4: begin commit(0, 1); flush_i = 1'b1; end
            5: begin check_done_i[1] = 1'b1; expect_rel(1, 0, t0 + 6); end
            default: ;
         endcase
         #1;
         if (r == 5) begin
            checks++;
            if (busy_o[1] !== 1'b1) begin failures++; $display("FAIL collision_busy: got %b expected 1", busy_o[1]); end
         end
         if (r == 7) begin
            checks++;
            if (busy_o !== 4'b0000) begin failures++; $display("FAIL collision_idle: got %b expected 0000", busy_o); end
            checks++;
            if (error_o !== 1'b0) begin failures++; $display("FAIL collision_error: got %b expected 0", error_o); end
         end
      end
      drain("collision");
   endtask

   task automatic test_watchdog();
      int   t0 = 0;
      logic exp_to;
      for (int r = 0; r <= 16; r++) begin
         tick();
         if (r == 0) t0 = cyc;
         case (r)
            0:  alloc(2);
            1:  begin commit(0, 2); expect_rel(2, 0, t0 + 6); end
            8:  alloc(2);
            9:  commit(1, 2);
            13: begin check_done_i[2] = 1'b1; expect_rel(2, 0, t0 + 14); end
            default: ;
         endcase
         #1;
         exp_to = (r == 5);
         checks++;
         if (timeout_o !== exp_to) begin
            failures++;
            $display("FAIL watchdog_timeout r%0d: got %b expected %b", r, timeout_o, exp_to);
         end
         if (r == 7 || r == 15) begin
            checks++;
            if (busy_o !== 4'b0000) begin failures++; $display("FAIL watchdog_idle r%0d: got %b expected 0000", r, busy_o); end
         end
      end
      checks++;
      if (error_o !== 1'b0) begin failures++; $display("FAIL watchdog_error: got %b expected 0", error_o); end
      drain("watchdog");
   endtask

   task automatic test_back_to_back();
      int t0 = 0;
      for (int r = 0; r <= 9; r++) begin
         tick();
         if (r == 0) t0 = cyc;
         case (r)
            0, 1, 2, 3: alloc(r);
            4: begin commit(0, 0); commit(1, 1); end
            5: begin commit(0, 2); commit(1, 3); end
            6: begin
               check_done_i = 4'b1111;
               expect_rel(0, 0, t0 + 7);
               expect_rel(1, 1, t0 + 7);
               expect_rel(2, 0, t0 + 8);
               expect_rel(3, 1, t0 + 8);
            end
            default: ;
         endcase
         #1;
         if (r == 7) begin
            checks++;
            if (busy_o !== 4'b1111) begin failures++; $display("FAIL b2b_busy7: got %b expected 1111", busy_o); end
         end
         if (r == 8) begin
            checks++;
            if (busy_o !== 4'b1100) begin failures++; $display("FAIL b2b_busy8: got %b expected 1100", busy_o); end
         end
         if (r == 9) begin
            checks++;
            if (busy_o !== 4'b0000) begin failures++; $display("FAIL b2b_busy9: got %b expected 0000", busy_o); end
         end
      end
      drain("b2b");
   endtask

   task automatic test_reuse();
      int t0 = 0;
      for (int r = 0; r <= 8; r++) begin
         tick();
         if (r == 0) t0 = cyc;
         case (r)
            0: alloc(0);
            1: commit(0, 0);
            3: begin check_done_i[0] = 1'b1; expect_rel(0, 0, t0 + 4); end
            4: alloc(0);
            5: alloc(0);
            6: begin flush_i = 1'b1; expect_rel(0, 0, t0 + 7); end
            default: ;
         endcase
         #1;
         if (r == 5) begin
            checks++;
            if (busy_o[0] !== 1'b1) begin failures++; $display("FAIL reuse_busy: got %b expected 1", busy_o[0]); end
            checks++;
            if (error_o !== 1'b0) begin failures++; $display("FAIL reuse_error: got %b expected 0", error_o); end
         end
         if (r == 6) begin
            checks++;
            if (error_o !== 1'b1) begin failures++; $display("FAIL busy_alloc_error: got %b expected 1", error_o); end
         end
         if (r == 8) begin
            checks++;
            if (busy_o !== 4'b0000) begin failures++; $display("FAIL reuse_idle: got %b expected 0000", busy_o); end
            checks++;
            if (error_o !== 1'b1) begin failures++; $display("FAIL error_sticky: got %b expected 1", error_o); end
         end
      end
      drain("reuse");
   endtask

   task automatic test_reset_mid();
      for (int r = 0; r <= 3; r++) begin
         tick();
         case (r)
            0: alloc(0);
            1: commit(0, 0);
            2: alloc(1);
            default: ;
         endcase
      end
      #2;
      rst_i = 1'b1;
      #1;
      checks++;
      if (busy_o !== 4'b0000) begin failures++; $display("FAIL midreset_busy: got %b expected 0000", busy_o); end
      checks++;
      if (error_o !== 1'b0) begin failures++; $display("FAIL midreset_error: got %b expected 0", error_o); end
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      repeat (3) tick();
      checks++;
      if (busy_o !== 4'b0000) begin failures++; $display("FAIL midreset_after: got %b expected 0000", busy_o); end
      drain("midreset");
   endtask

   task automatic test_errors();
      tick();
      check_done_i[3] = 1'b1;
      tick();
      checks++;
      if (error_o !== 1'b1) begin failures++; $display("FAIL done_idle_error: got %b expected 1", error_o); end
      checks++;
      if (busy_o !== 4'b0000) begin failures++; $display("FAIL done_idle_busy: got %b expected 0000", busy_o); end
      test_reset();
      tick();
      commit(1, 1);
      tick();
      checks++;
      if (error_o !== 1'b1) begin failures++; $display("FAIL commit_idle_error: got %b expected 1", error_o); end
      checks++;
      if (busy_o !== 4'b0000) begin failures++; $display("FAIL commit_idle_busy: got %b expected 0000", busy_o); end
      repeat (2) tick();
      drain("errors");
   endtask

   initial begin
      idle();
      test_reset();
      test_lifetime();
      test_flush();
      test_collision();
      test_watchdog();
      test_back_to_back();
      test_reuse();
      test_reset_mid();
      test_errors();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
